calc_sequencer: RTL and testbench

//  Control FSM for the hex calculator datapath. It turns single-cycle keypad events (digit, operator,

---
 rtl/calc_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Hex calculator control sequencer.
// Turns keypad events into register strobes and drives the arithmetic unit.
module calc_sequencer #(
    parameter int DIGITS        = 4,
    parameter int ARITH_TIMEOUT = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       newhex,
    input  logic [3:0] hexcode,
    input  logic       newop,
    input  logic [1:0] opcode,
    input  logic       eq,
    input  logic       arith_done,
    input  logic       arith_ovf,
    output logic       v1_shift_hex,
    output logic       v1_clear_hex,
    output logic       v1_load_ans,
    output logic       v2_load_v1,
    output logic [3:0] hex_out,
    output logic       arith_start,
    output logic [1:0] arith_op,
    output logic       busy,
    output logic       error,
    output logic       key_dropped
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(ARITH_TIMEOUT + 1);

    typedef enum logic [2:0] {S_ENTRY, S_FLOW, S_CALC, S_WB, S_ERR} state_t;
    typedef enum logic [1:0] {EV_NONE, EV_HEX, EV_OP, EV_EQ} ev_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [TW-1:0] timer, timer_d;
    logic          op_valid, op_valid_d;
    logic          chain, chain_d;
    logic          chain_copy, chain_copy_d;
    logic [1:0]    pend_op_d, next_op, next_op_d;
    logic          buf_valid, buf_valid_d;
    ev_t           buf_kind, buf_kind_d;
    logic [3:0]    buf_data, buf_data_d;
    ev_t           live_kind, ev_kind;
    logic [3:0]    live_data, ev_data;
    logic          replay, hold, timeout;
    logic          shift_d, clear_d, load_d, v2_d, start_d, drop_d;
    logic [3:0]    hex_d;

    // Live key with eq > newop > newhex priority
    always_comb begin
        live_kind = EV_NONE;
        live_data = hexcode;
        if (eq) begin
            live_kind = EV_EQ;
            live_data = 4'h0;
        end else if (newop) begin
            live_kind = EV_OP;
            live_data = {2'b00, opcode};
        end else if (newhex) begin
            live_kind = EV_HEX;
        end
    end

    // The buffered key is replayed once the chain copy cycle has passed
    assign replay  = (state == S_FLOW) && !chain_copy && buf_valid;
    assign hold    = (state == S_CALC) || (state == S_WB) ||
                     ((state == S_FLOW) && chain_copy);
    assign ev_kind = replay ? buf_kind : live_kind;
    assign ev_data = replay ? buf_data : live_data;
    assign timeout = (timer == TW'(ARITH_TIMEOUT - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= S_ENTRY;
        else       state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            S_ENTRY: begin
                if (ev_kind == EV_EQ || ev_kind == EV_OP)
                    state_d = op_valid ? S_CALC : S_FLOW;
            end
            S_FLOW: begin
                if (!chain_copy) begin
                    if (ev_kind == EV_HEX)
                        state_d = S_ENTRY;
                    else if (ev_kind == EV_EQ && op_valid)
                        state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (arith_done)   state_d = arith_ovf ? S_ERR : S_WB;
                else if (timeout) state_d = S_ERR;
            end
            S_WB:    state_d = S_FLOW;
            S_ERR:   if (live_kind == EV_EQ) state_d = S_ENTRY;
            default: state_d = S_ENTRY;
        endcase
    end

    // Output and bookkeeping next values
    always_comb begin
        shift_d      = 1'b0;
        clear_d      = 1'b0;
        load_d       = 1'b0;
        v2_d         = 1'b0;
        start_d      = 1'b0;
        drop_d       = 1'b0;
        hex_d        = 4'h0;
        cnt_d        = cnt;
        op_valid_d   = op_valid;
        pend_op_d    = arith_op;
        next_op_d    = next_op;
        chain_d      = chain;
        chain_copy_d = 1'b0;
        buf_valid_d  = buf_valid;
        buf_kind_d   = buf_kind;
        buf_data_d   = buf_data;
        timer_d      = (state == S_CALC) ? timer + TW'(1) : '0;
        if (hold && live_kind != EV_NONE) begin
            if (!buf_valid) begin
                buf_valid_d = 1'b1;
                buf_kind_d  = live_kind;
                buf_data_d  = live_data;
            end else begin
                drop_d = 1'b1;
            end
        end
        if (replay) begin
            buf_valid_d = 1'b0;
            drop_d      = (live_kind != EV_NONE);
        end
        unique case (state)
            S_ENTRY: begin
                if (ev_kind == EV_HEX && cnt < CW'(DIGITS)) begin
                    shift_d = 1'b1;
                    hex_d   = ev_data;
                    cnt_d   = cnt + CW'(1);
                end else if (ev_kind == EV_OP && !op_valid) begin
                    v2_d       = 1'b1;
                    pend_op_d  = ev_data[1:0];
                    op_valid_d = 1'b1;
                end else if (ev_kind == EV_OP) begin
                    start_d   = 1'b1;
                    chain_d   = 1'b1;
                    next_op_d = ev_data[1:0];
                end else if (ev_kind == EV_EQ && op_valid) begin
                    start_d = 1'b1;
                    chain_d = 1'b0;
                end
            end
            S_FLOW: begin
                if (chain_copy) begin
                    v2_d       = 1'b1;
                    pend_op_d  = next_op;
                    op_valid_d = 1'b1;
                end else if (ev_kind == EV_HEX) begin
                    clear_d = 1'b1;
                    hex_d   = ev_data;
                    cnt_d   = CW'(1);
                end else if (ev_kind == EV_OP) begin
                    v2_d       = 1'b1;
                    pend_op_d  = ev_data[1:0];
                    op_valid_d = 1'b1;
                end else if (ev_kind == EV_EQ && op_valid) begin
                    start_d = 1'b1;
                    chain_d = 1'b0;
                end
            end
            S_CALC: begin
                if (state_d == S_ERR) buf_valid_d = 1'b0;
            end
            S_WB: begin
                load_d       = 1'b1;
                cnt_d        = '0;
                chain_copy_d = chain;
                if (!chain) op_valid_d = 1'b0;
            end
            S_ERR: begin
                buf_valid_d = 1'b0;
                if (live_kind == EV_EQ) begin
                    clear_d    = 1'b1;
                    op_valid_d = 1'b0;
                    cnt_d      = '0;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and sequencer bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            v1_shift_hex <= 1'b0;
            v1_clear_hex <= 1'b0;
            v1_load_ans  <= 1'b0;
            v2_load_v1   <= 1'b0;
            hex_out      <= 4'h0;
            arith_start  <= 1'b0;
            arith_op     <= 2'b00;
            busy         <= 1'b0;
            error        <= 1'b0;
            key_dropped  <= 1'b0;
            cnt          <= '0;
            timer        <= '0;
            op_valid     <= 1'b0;
            chain        <= 1'b0;
            chain_copy   <= 1'b0;
            next_op      <= 2'b00;
            buf_valid    <= 1'b0;
            buf_kind     <= EV_NONE;
            buf_data     <= 4'h0;
        end else begin
            v1_shift_hex <= shift_d;
            v1_clear_hex <= clear_d;
            v1_load_ans  <= load_d;
            v2_load_v1   <= v2_d;
            hex_out      <= hex_d;
            arith_start  <= start_d;
            arith_op     <= pend_op_d;
            busy         <= (state_d == S_CALC) || (state_d == S_WB);
            error        <= (state_d == S_ERR);
            key_dropped  <= drop_d;
            cnt          <= cnt_d;
            timer        <= timer_d;
            op_valid     <= op_valid_d;
            chain        <= chain_d;
            chain_copy   <= chain_copy_d;
            next_op      <= next_op_d;
            buf_valid    <= buf_valid_d;
            buf_kind     <= buf_kind_d;
            buf_data     <= buf_data_d;
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed vector table, hand-written
// timeout/reset sequences and random keys against a behavioural model.
module tb_calc_sequencer;
    localparam int NDIG = 4;
    localparam int TOUT = 64;
    localparam int M_ENTRY = 0, M_FLOW = 1, M_CALC = 2, M_WB = 3, M_ERR = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       newhex = 1'b0, newop = 1'b0, eq = 1'b0;
    logic [3:0] hexcode = 4'h0;
    logic [1:0] opcode = 2'b00;
    logic       arith_done = 1'b0, arith_ovf = 1'b0;
    logic       v1_shift_hex, v1_clear_hex, v1_load_ans, v2_load_v1;
    logic [3:0] hex_out;
    logic       arith_start;
    logic [1:0] arith_op;
    logic       busy, error, key_dropped;

    calc_sequencer dut (
        .clock(clock), .reset(reset),
        .newhex(newhex), .hexcode(hexcode),
        .newop(newop), .opcode(opcode), .eq(eq),
        .arith_done(arith_done), .arith_ovf(arith_ovf),
        .v1_shift_hex(v1_shift_hex), .v1_clear_hex(v1_clear_hex),
        .v1_load_ans(v1_load_ans), .v2_load_v1(v2_load_v1),
        .hex_out(hex_out), .arith_start(arith_start),
        .arith_op(arith_op), .busy(busy), .error(error),
        .key_dropped(key_dropped)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    int         md = M_ENTRY;
    int         m_cnt = 0, m_tmr = 0;
    bit         m_opv = 0, m_chain = 0, m_copy = 0;
    logic [1:0] m_pend = 0, m_next = 0;
    int         m_buf[$];
    logic       e_sh, e_cl, e_ld, e_v2, e_st, e_dr;
    logic [3:0] e_hx;

    function automatic logic [13:0] act();
        return {v1_shift_hex, v1_clear_hex, v1_load_ans, v2_load_v1,
                hex_out, arith_start, arith_op, busy, error,
                key_dropped};
    endfunction

    function automatic logic [13:0] mexp();
        return {e_sh, e_cl, e_ld, e_v2, e_hx, e_st, m_pend,
                (md == M_CALC || md == M_WB), (md == M_ERR), e_dr};
    endfunction

    task automatic chk(input string nm, input logic [13:0] a,
                       input logic [13:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, a, e);
        end
    endtask

    task automatic m_launch();
        e_st = 1;
        m_tmr = 0;
        md = M_CALC;
    endtask

    task automatic m_apply(input int k, input logic [3:0] d);
        if (md == M_ENTRY) begin
            if (k == 1 && m_cnt < NDIG) begin
                e_sh = 1; e_hx = d; m_cnt++;
            end else if (k == 2 && !m_opv) begin
                e_v2 = 1; m_pend = d[1:0]; m_opv = 1; md = M_FLOW;
            end else if (k == 2) begin
                m_launch(); m_chain = 1; m_next = d[1:0];
            end else if (k == 3 && m_opv) begin
                m_launch(); m_chain = 0;
            end else if (k == 3) begin
                md = M_FLOW;
            end
        end else begin
            if (k == 1) begin
                e_cl = 1; e_hx = d; m_cnt = 1; md = M_ENTRY;
            end else if (k == 2) begin
                e_v2 = 1; m_pend = d[1:0]; m_opv = 1;
            end else if (k == 3 && m_opv) begin
                m_launch(); m_chain = 0;
            end
        end
    endtask

    task automatic m_capture(input int k, input logic [3:0] d);
        if (k != 0) begin
            if (m_buf.size() == 0) m_buf.push_back(k * 16 + int'(d));
            else e_dr = 1;
        end
    endtask

    task automatic m_step(input bit rst, input bit nh, input bit no,
                          input bit e, input logic [3:0] hc,
                          input logic [1:0] oc, input bit dn,
                          input bit ov);
        int k;
        logic [3:0] d;
        int b;
        e_sh = 0; e_cl = 0; e_ld = 0; e_v2 = 0; e_st = 0; e_dr = 0;
        e_hx = 0;
        k = e ? 3 : no ? 2 : nh ? 1 : 0;
        d = no ? {2'b00, oc} : hc;
        if (rst) begin
            md = M_ENTRY; m_cnt = 0; m_opv = 0; m_chain = 0;
            m_copy = 0; m_pend = 0; m_next = 0; m_buf.delete();
            return;
        end
        case (md)
            M_CALC: begin
                m_capture(k, d);
                m_tmr++;
                if (dn) md = ov ? M_ERR : M_WB;
                else if (m_tmr == TOUT) md = M_ERR;
                if (md == M_ERR) m_buf.delete();
            end
            M_WB: begin
                m_capture(k, d);
                e_ld = 1; m_cnt = 0;
                if (m_chain) m_copy = 1;
                else m_opv = 0;
                md = M_FLOW;
            end
            M_FLOW: begin
                if (m_copy) begin
                    m_capture(k, d);
                    e_v2 = 1; m_pend = m_next; m_opv = 1; m_copy = 0;
                end else if (m_buf.size() != 0) begin
                    if (k != 0) e_dr = 1;
                    b = m_buf.pop_front();
                    m_apply(b / 16, 4'(b % 16));
                end else begin
                    m_apply(k, d);
                end
            end
            M_ENTRY: m_apply(k, d);
            default: begin
                if (k == 3) begin
                    e_cl = 1; m_opv = 0; m_cnt = 0; md = M_ENTRY;
                end
            end
        endcase
    endtask

    task automatic cyc(input bit rst, input bit nh, input bit no,
                       input bit e, input logic [3:0] hc,
                       input logic [1:0] oc, input bit dn,
                       input bit ov);
        reset = rst; newhex = nh; newop = no; eq = e;
        hexcode = hc; opcode = oc; arith_done = dn; arith_ovf = ov;
        @(posedge clock);
        m_step(rst, nh, no, e, hc, oc, dn, ov);
        @(negedge clock);
    endtask

    task automatic key(input int k, input logic [3:0] d);
        cyc(0, k == 1, k == 2, k == 3, d, d[1:0], 0, 0);
    endtask

    typedef struct {
        int         k;
        logic [3:0] d;
        bit         dn;
        bit         ov;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int k, int d, bit dn, bit ov,
                                bit sh, bit cl, bit ld, bit v2, int hx,
                                bit st, int op, bit bs, bit er, bit dr);
        vec_t v;
        v.k = k; v.d = 4'(d); v.dn = dn; v.ov = ov;
        v.exp = {sh, cl, ld, v2, 4'(hx), st, 2'(op), bs, er, dr};
        tbl.push_back(v);
    endfunction

    initial begin
        // digits 1..5, fifth ignored
        add(0,0,0,0, 0,0,0,0,0,0,0,0,0,0);
        add(1,1,0,0, 1,0,0,0,1,0,0,0,0,0);
        add(1,2,0,0, 1,0,0,0,2,0,0,0,0,0);
        add(1,3,0,0, 1,0,0,0,3,0,0,0,0,0);
        add(1,4,0,0, 1,0,0,0,4,0,0,0,0,0);
        add(1,5,0,0, 0,0,0,0,0,0,0,0,0,0);
        // op, overwrite with 3, equals, result
        add(2,1,0,0, 0,0,0,1,0,0,1,0,0,0);
        add(1,3,0,0, 0,1,0,0,3,0,1,0,0,0);
        add(3,0,0,0, 0,0,0,0,0,1,1,1,0,0);
        add(0,0,0,0, 0,0,0,0,0,0,1,1,0,0);
        add(0,0,0,0, 0,0,0,0,0,0,1,1,0,0);
        add(0,0,0,0, 0,0,0,0,0,0,1,1,0,0);
        add(0,0,0,0, 0,0,0,0,0,0,1,1,0,0);
        add(0,0,1,0, 0,0,0,0,0,0,1,1,0,0);
        add(0,0,0,0, 0,0,1,0,0,0,1,0,0,0);
        add(3,0,0,0, 0,0,0,0,0,0,1,0,0,0);
        // chained operator 2 + 3 -
        add(1,2,0,0, 0,1,0,0,2,0,1,0,0,0);
        add(2,1,0,0, 0,0,0,1,0,0,1,0,0,0);
        add(1,3,0,0, 0,1,0,0,3,0,1,0,0,0);
        add(2,2,0,0, 0,0,0,0,0,1,1,1,0,0);
        add(0,0,1,0, 0,0,0,0,0,0,1,1,0,0);
        add(0,0,0,0, 0,0,1,0,0,0,1,0,0,0);
        add(0,0,0,0, 0,0,0,1,0,0,2,0,0,0);
        add(0,0,0,0, 0,0,0,0,0,0,2,0,0,0);
        // keys while busy: 9 buffered, 8 dropped, 9 replayed
        add(1,1,0,0, 0,1,0,0,1,0,2,0,0,0);
        add(3,0,0,0, 0,0,0,0,0,1,2,1,0,0);
        add(1,9,0,0, 0,0,0,0,0,0,2,1,0,0);
        add(1,8,0,0, 0,0,0,0,0,0,2,1,0,1);
        add(0,0,1,0, 0,0,0,0,0,0,2,1,0,0);
        add(0,0,0,0, 0,0,1,0,0,0,2,0,0,0);
        add(0,0,0,0, 0,1,0,0,9,0,2,0,0,0);
        // overflow -> error, clear with eq
        add(2,3,0,0, 0,0,0,1,0,0,3,0,0,0);
        add(3,0,0,0, 0,0,0,0,0,1,3,1,0,0);
        add(0,0,1,1, 0,0,0,0,0,0,3,0,1,0);
        add(0,0,0,0, 0,0,0,0,0,0,3,0,1,0);
        add(1,5,0,0, 0,0,0,0,0,0,3,0,1,0);
        add(3,0,0,0, 0,1,0,0,0,0,3,0,0,0);
        add(1,6,0,0, 1,0,0,0,6,0,3,0,0,0);

        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset", act(), 14'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(0, tbl[i].k == 1, tbl[i].k == 2, tbl[i].k == 3,
                tbl[i].d, tbl[i].d[1:0], tbl[i].dn, tbl[i].ov);
            chk($sformatf("vec%0d", i), act(), tbl[i].exp);
        end

        // arithmetic timeout
        key(2, 0);
        chk("to_op", act(), {4'b0001, 4'h0, 1'b0, 2'd0, 3'b000});
        key(3, 0);
        chk("to_start", act(), {4'b0000, 4'h0, 1'b1, 2'd0, 3'b100});
        for (int i = 1; i <= TOUT; i++) begin
            key(0, 0);
            if (i == TOUT - 1)
                chk("to_pre", act(), {4'b0000, 4'h0, 1'b0, 2'd0, 3'b100});
            if (i == TOUT)
                chk("to_err", act(), {4'b0000, 4'h0, 1'b0, 2'd0, 3'b010});
        end
        key(3, 0);
        chk("to_clr", act(), {4'b0100, 4'h0, 1'b0, 2'd0, 3'b000});

        // reset while calculating, late done ignored
        key(2, 1);
        key(3, 0);
        chk("rc_start", act(), {4'b0000, 4'h0, 1'b1, 2'd1, 3'b100});
        key(0, 0);
        key(0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rc_reset", act(), 14'd0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("rc_late", act(), 14'd0);
        key(1, 7);
        chk("rc_hex", act(), {4'b1000, 4'h7, 1'b0, 2'd0, 3'b000});

        // random keys against the model
        for (int i = 0; i < 3000; i++) begin
            bit rst, nh, no, e, dn, ov;
            rst = ($urandom_range(0, 199) == 0);
            nh = ($urandom_range(0, 99) < 30);
            no = ($urandom_range(0, 99) < 12);
            e = ($urandom_range(0, 99) < 10);
            dn = ($urandom_range(0, 99) < 15);
            ov = ($urandom_range(0, 9) == 0);
            cyc(rst, nh, no, e, 4'($urandom_range(0, 15)),
                2'($urandom_range(0, 3)), dn, ov);
            chk($sformatf("rand%0d", i), act(), mexp());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
